// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: func3 encodings, LSU state enum and
// the legality/alignment rule used when an operation is issued.
package riscv_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   // True when the operation must be rejected: unknown func3 for its
   // direction, or a halfword/word access that is not naturally aligned.
   function automatic logic lsu_bad(input logic st, input logic [2:0] f3,
                                    input logic [1:0] off);
      logic legal;
      logic mis;
      if (st)
         legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
      else
         legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
      mis = ((f3[1:0] == 2'b01) && off[0]) ||
            ((f3[1:0] == 2'b10) && (off != 2'b00));
      return !legal || mis;
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Load data alignment: pick the addressed lane of the read word and
// sign- or zero-extend it according to func3.
module riscv_lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [31:0] shifted;

   assign shifted = rdata >> {byte_off, 3'b000};

   // Extend the selected lane to a full register value.
   always_comb begin
      data = shifted;
      case (func3)
         F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
         F3_LW:   data = rdata;
         F3_LBU:  data = {24'd0, shifted[7:0]};
         F3_LHU:  data = {16'd0, shifted[15:0]};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: single outstanding access, IDLE/REQ/WAIT/DONE
// sequencing, lane-positioned store data and aligned load writeback.
module riscv_lsu
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  func3,
   input  logic [31:0] addr,
   input  logic [31:0] st_data,
   input  logic [4:0]  rd_addr,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        wb_en,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   lsu_state_t  state_reg, state_next;
   logic        is_store_reg;
   logic [2:0]  func3_reg;
   logic [1:0]  byte_off_reg;
   logic        err_reg;
   logic [4:0]  rd_addr_reg;
   logic [31:0] rdata_reg;
   logic [31:0] mem_addr_reg;
   logic [3:0]  mem_be_reg;
   logic [31:0] mem_wdata_reg;

   logic        issue;
   logic        bad_next;
   logic        capture;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;

   assign issue    = (state_reg == IDLE) && start;
   assign bad_next = lsu_bad(is_store, func3, addr[1:0]);
   assign capture  = mem_rvalid &&
                     (((state_reg == REQ) && mem_gnt) || (state_reg == WAIT));

   // Byte enables and replicated store data derived from the issuing request.
   always_comb begin
      be_next    = 4'b1111;
      wdata_next = st_data;
      case (func3[1:0])
         2'b00: begin
            be_next    = 4'b0001 << addr[1:0];
            wdata_next = {4{st_data[7:0]}};
         end
         2'b01: begin
            be_next    = 4'b0011 << addr[1:0];
            wdata_next = {2{st_data[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = st_data;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic; rejected requests skip the memory entirely.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start) state_next = bad_next ? DONE : REQ;
         REQ:  if (mem_gnt) state_next = mem_rvalid ? DONE : WAIT;
         WAIT: if (mem_rvalid) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operation latches at issue and response capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_store_reg  <= 1'b0;
         func3_reg     <= 3'd0;
         byte_off_reg  <= 2'd0;
         err_reg       <= 1'b0;
         rd_addr_reg   <= 5'd0;
         rdata_reg     <= 32'd0;
         mem_addr_reg  <= 32'd0;
         mem_be_reg    <= 4'd0;
         mem_wdata_reg <= 32'd0;
      end else begin
         if (issue) begin
            is_store_reg  <= is_store;
            func3_reg     <= func3;
            byte_off_reg  <= addr[1:0];
            err_reg       <= bad_next;
            rd_addr_reg   <= rd_addr;
            mem_addr_reg  <= {addr[31:2], 2'b00};
            mem_be_reg    <= be_next;
            mem_wdata_reg <= wdata_next;
         end
         if (capture)
            rdata_reg <= mem_rdata;
      end
   end

   riscv_lsu_align u_align (
      .func3    (func3_reg),
      .byte_off (byte_off_reg),
      .rdata    (rdata_reg),
      .data     (wb_data)
   );

   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == DONE);
   assign err       = done && err_reg;
   assign mem_req   = (state_reg == REQ);
   assign mem_we    = mem_req && is_store_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_be    = mem_be_reg;
   assign mem_wdata = mem_wdata_reg;
   assign wb_en     = done && !is_store_reg && !err_reg && (rd_addr_reg != 5'd0);
   assign wb_addr   = rd_addr_reg;

endmodule
